// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared record kinds, entry flags and head-kind priority helper for the trace unit
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        TK_REG   = 2'd0,
        TK_LOAD  = 2'd1,
        TK_STORE = 2'd2,
        TK_HALT  = 2'd3
    } trace_kind_e;

    // Bit order matches the record emission order: reg_we is emitted first, halt last.
    typedef struct packed {
        logic halt;
        logic mem_we;
        logic mem_re;
        logic reg_we;
    } trace_flags_t;

    // First kind still pending, in REG, LOAD, STORE, HALT order.
    function automatic trace_kind_e first_kind(input logic [3:0] pend);
        return pend[0] ? TK_REG : pend[1] ? TK_LOAD : pend[2] ? TK_STORE : TK_HALT;
    endfunction

endpackage

// File: rtl/cpu_trace_unit_trace_fifo.sv
// trace_fifo: synchronous FIFO with wrap-bit pointers; a push to a full FIFO is accepted when it pops in the same cycle
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push, do_pop;

    // Flags, qualified handshakes and next pointers.
    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        dout    = mem_q[rd_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cpu_trace_unit.sv
// cpu_trace_unit: captures retirement events into a FIFO, serialises them as REG/LOAD/STORE/HALT records and keeps saturating statistics
module cpu_trace_unit
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int REG_AW  = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 32,
    localparam int SEL_W  = ADDR_W > REG_AW ? ADDR_W : REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              reg_we,
    input  logic [REG_AW-1:0] reg_waddr,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              halt,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [1:0]        trc_kind,
    output logic [SEL_W-1:0]  trc_sel,
    output logic [DATA_W-1:0] trc_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              halted,
    output logic              done
);
    typedef struct packed {
        trace_flags_t      flags;
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] mwdata;
        logic [DATA_W-1:0] rdata;
    } entry_t;

    entry_t      in_e, head_e;
    logic        full, empty, active, accept, push, pop, drop, run;
    logic [3:0]  pending, kind_oh, mask_q, mask_d;
    trace_kind_e kind;
    logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
    logic        ovf_q, ovf_d, halted_q, halted_d;

    trace_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_e),
        .dout  (head_e),
        .full  (full),
        .empty (empty)
    );

    // Capture, serialiser handshake and next state of mask, counters and sticky flags.
    always_comb begin
        in_e         = '0;
        in_e.flags   = '{halt: halt, mem_we: mem_we, mem_re: mem_re, reg_we: reg_we};
        in_e.waddr   = reg_waddr;
        in_e.wdata   = reg_wdata;
        in_e.addr    = mem_addr;
        in_e.mwdata  = mem_wdata;
        in_e.rdata   = mem_rdata;
        run          = en & ~halted_q;
        active       = run & (reg_we | mem_re | mem_we | halt);
        pending      = head_e.flags & ~mask_q;
        kind         = first_kind(pending);
        kind_oh      = 4'b0001 << kind;
        accept       = ~empty & trc_ready;
        pop          = accept & ((pending & ~kind_oh) == 4'b0000);
        push         = active & (~full | pop);
        drop         = active & full & ~pop;
        mask_d       = pop ? 4'b0000 : accept ? (mask_q | kind_oh) : mask_q;
        cycle_d      = (run && ~&cycle_q) ? cycle_q + CNT_W'(1) : cycle_q;
        inst_d       = (run && (halt | reg_we | mem_we) && ~&inst_q) ? inst_q + CNT_W'(1) : inst_q;
        drop_d       = (drop && ~&drop_q) ? drop_q + CNT_W'(1) : drop_q;
        ovf_d        = ovf_q | drop;
        halted_d     = halted_q | (active & halt);
    end

    // Record port and status outputs; the record fields read zero while the FIFO is empty.
    always_comb begin
        trc_valid   = ~empty;
        trc_kind    = empty ? 2'd0 : kind;
        trc_sel     = (empty || kind == TK_HALT) ? '0 :
                      kind == TK_REG ? SEL_W'(head_e.waddr) : SEL_W'(head_e.addr);
        trc_data    = empty ? '0 :
                      kind == TK_REG   ? head_e.wdata :
                      kind == TK_LOAD  ? head_e.rdata :
                      kind == TK_STORE ? head_e.mwdata : '0;
        cycle_count = cycle_q;
        inst_count  = inst_q;
        drop_count  = drop_q;
        overflow    = ovf_q;
        halted      = halted_q;
        done        = halted_q & empty;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q   <= '0;
            cycle_q  <= '0;
            inst_q   <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            cycle_q  <= cycle_d;
            inst_q   <= inst_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_cpu_trace_unit.sv
// tb_cpu_trace_unit: directed scenarios plus randomized traffic checked against a queue-based record model
module tb_cpu_trace_unit;
    logic        clk = 0, rst = 0, en = 0, reg_we = 0, mem_re = 0, mem_we = 0, halt = 0, trc_ready = 0;
    logic [3:0]  reg_waddr = 0;
    logic [15:0] reg_wdata = 0, mem_addr = 0, mem_wdata = 0, mem_rdata = 0;
    logic        trc_valid, overflow, halted, done;
    logic [1:0]  trc_kind;
    logic [15:0] trc_sel, trc_data;
    logic [31:0] cycle_count, inst_count, drop_count;
    int          checks = 0, errors = 0;

    logic [34:0] obs;
    logic [98:0] stat;
    assign obs  = {trc_valid, trc_kind, trc_sel, trc_data};
    assign stat = {cycle_count, inst_count, drop_count, overflow, halted, done};

    cpu_trace_unit #(.DATA_W(16), .ADDR_W(16), .REG_AW(4), .DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .halt(halt), .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind), .trc_sel(trc_sel),
        .trc_data(trc_data), .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
        .overflow(overflow), .halted(halted), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending records plus a queue of per-entry record counts.
    typedef struct {
        logic [1:0]  k;
        logic [15:0] s;
        logic [15:0] d;
    } rec_t;
    rec_t rq[$];
    int   cq[$];
    int   m_cyc, m_inst, m_drop;
    bit   m_ovf, m_halted;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rq.delete(); cq.delete();
            m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 0; m_halted = 0;
        end else begin : mdl
            bit act, was_full, popped;
            int n;
            act = en && !m_halted && (reg_we || mem_re || mem_we || halt);
            was_full = cq.size() == 8;
            popped = 0;
            if (cq.size() > 0 && trc_ready) begin
                void'(rq.pop_front());
                cq[0] = cq[0] - 1;
                if (cq[0] == 0) begin popped = 1; void'(cq.pop_front()); end
            end
            if (act && (!was_full || popped)) begin
                n = 0;
                if (reg_we) begin rq.push_back('{2'd0, 16'(reg_waddr), reg_wdata}); n++; end
                if (mem_re) begin rq.push_back('{2'd1, mem_addr, mem_rdata}); n++; end
                if (mem_we) begin rq.push_back('{2'd2, mem_addr, mem_wdata}); n++; end
                if (halt)   begin rq.push_back('{2'd3, 16'd0, 16'd0}); n++; end
                cq.push_back(n);
            end else if (act) begin
                m_drop++; m_ovf = 1;
            end
            if (en && !m_halted) begin
                m_cyc++;
                if (halt || reg_we || mem_we) m_inst++;
            end
            if (act && halt) m_halted = 1;
        end
    end

    task automatic idle();
        reg_we = 0; mem_re = 0; mem_we = 0; halt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; en = 0; trc_ready = 0; idle();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        #1 rst = 1;
        #1;
        checks++;
        if ({obs, stat} !== '0) begin errors++; $display("FAIL reset_async got %h %h exp 0", obs, stat); end
        repeat (2) @(negedge clk);
        checks++;
        if ({obs, stat} !== '0) begin errors++; $display("FAIL reset_hold got %h %h exp 0", obs, stat); end
        rst = 0;
    endtask

    task automatic test_single_write();
        do_reset();
        en = 1; trc_ready = 1; reg_we = 1; reg_waddr = 4'd3; reg_wdata = 16'h1234;
        @(negedge clk);
        idle();
        checks++;
        if (obs !== {1'b1, 2'd0, 16'd3, 16'h1234}) begin errors++; $display("FAIL single_rec got %h exp %h", obs, {1'b1, 2'd0, 16'd3, 16'h1234}); end
        checks++;
        if ({cycle_count, inst_count} !== {32'd1, 32'd1}) begin errors++; $display("FAIL single_counts got %0d %0d exp 1 1", cycle_count, inst_count); end
        @(negedge clk);
        checks++;
        if (trc_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", trc_valid); end
    endtask

    task automatic test_multi_flag();
        do_reset();
        en = 1; trc_ready = 1; reg_we = 1; reg_waddr = 4'd5; reg_wdata = 16'h00AA;
        mem_re = 1; mem_addr = 16'h0040; mem_rdata = 16'hBEEF;
        @(negedge clk);
        idle();
        checks++;
        if (obs !== {1'b1, 2'd0, 16'd5, 16'h00AA}) begin errors++; $display("FAIL multi_reg got %h", obs); end
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 2'd1, 16'h0040, 16'hBEEF}) begin errors++; $display("FAIL multi_load got %h", obs); end
        @(negedge clk);
        checks++;
        if ({trc_valid, inst_count} !== {1'b0, 32'd1}) begin errors++; $display("FAIL multi_end got v=%b inst=%0d exp v=0 inst=1", trc_valid, inst_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        en = 1; trc_ready = 0;
        for (int i = 0; i < 10; i++) begin
            mem_we = 1; mem_addr = 16'h0030 + 16'(i); mem_wdata = 16'hA000 + 16'(i);
            @(negedge clk);
        end
        idle();
        checks++;
        if ({drop_count, overflow, inst_count} !== {32'd2, 1'b1, 32'd10}) begin
            errors++; $display("FAIL ovf_stats got drop=%0d ovf=%b inst=%0d exp 2 1 10", drop_count, overflow, inst_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== {1'b1, 2'd2, 16'h0030 + 16'(i), 16'hA000 + 16'(i)}) begin errors++; $display("FAIL ovf_rec%0d got %h", i, obs); end
            trc_ready = 1;
            @(negedge clk);
        end
        checks++;
        if (trc_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", trc_valid); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        do_reset();
        en = 1; trc_ready = 0; mem_we = 1; mem_addr = 16'h0020; mem_wdata = 16'h7000;
        for (int c = 1; c <= 12; c++) begin
            int pushed;
            @(negedge clk);
            pushed = c < 4 ? c : 4;
            checks++;
            if (k < pushed) begin
                if (obs !== {1'b1, 2'd2, 16'h0020 + 16'(k), 16'h7000 + 16'(k)}) begin errors++; $display("FAIL bp_rec%0d cyc%0d got %h", k, c, obs); end
            end else if (trc_valid !== 1'b0) begin
                errors++; $display("FAIL bp_extra cyc%0d got valid %b exp 0", c, trc_valid);
            end
            trc_ready = c[0];
            if (trc_ready && k < pushed) k++;
            mem_we = c < 4; mem_addr = 16'h0020 + 16'(c); mem_wdata = 16'h7000 + 16'(c);
        end
        checks++;
        if (k !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", k); end
    endtask

    task automatic test_halt();
        do_reset();
        en = 1; trc_ready = 1; mem_we = 1; mem_addr = 16'h0010; mem_wdata = 16'h0007;
        @(negedge clk);
        mem_we = 0; halt = 1;
        checks++;
        if (obs !== {1'b1, 2'd2, 16'h0010, 16'h0007}) begin errors++; $display("FAIL halt_store got %h", obs); end
        @(negedge clk);
        halt = 0; reg_we = 1; reg_waddr = 4'd9; reg_wdata = 16'h5555;
        checks++;
        if ({obs, halted, done} !== {1'b1, 2'd3, 16'd0, 16'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL halt_rec got %h h=%b d=%b", obs, halted, done); end
        @(negedge clk);
        checks++;
        if ({trc_valid, done, cycle_count, inst_count} !== {1'b0, 1'b1, 32'd2, 32'd2}) begin
            errors++; $display("FAIL halt_done got v=%b d=%b cyc=%0d inst=%0d exp 0 1 2 2", trc_valid, done, cycle_count, inst_count);
        end
        mem_we = 1;
        repeat (3) @(negedge clk);
        idle();
        checks++;
        if ({trc_valid, done, cycle_count, inst_count} !== {1'b0, 1'b1, 32'd2, 32'd2}) begin
            errors++; $display("FAIL halt_frozen got v=%b d=%b cyc=%0d inst=%0d exp 0 1 2 2", trc_valid, done, cycle_count, inst_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1; trc_ready = 0;
        for (int i = 0; i < 3; i++) begin
            reg_we = 1; reg_waddr = 4'(i); reg_wdata = 16'h0100 + 16'(i);
            @(negedge clk);
        end
        idle();
        checks++;
        if (trc_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b exp 1", trc_valid); end
        #2 rst = 1;
        #1;
        checks++;
        if ({obs, stat} !== '0) begin errors++; $display("FAIL mid_async got %h %h exp 0", obs, stat); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if ({trc_valid, cycle_count, inst_count, drop_count} !== {1'b0, 32'd1, 32'd0, 32'd0}) begin
            errors++; $display("FAIL mid_after got v=%b cyc=%0d inst=%0d drop=%0d exp 0 1 0 0", trc_valid, cycle_count, inst_count, drop_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 700; i++) begin
            checks++;
            if (cq.size() > 0) begin
                if (obs !== {1'b1, rq[0].k, rq[0].s, rq[0].d}) begin errors++; $display("FAIL rnd_rec cyc%0d got %h exp %h", i, obs, {1'b1, rq[0].k, rq[0].s, rq[0].d}); end
            end else if (trc_valid !== 1'b0) begin
                errors++; $display("FAIL rnd_idle cyc%0d got valid %b exp 0", i, trc_valid);
            end
            checks++;
            if (stat !== {32'(m_cyc), 32'(m_inst), 32'(m_drop), m_ovf, m_halted, m_halted && cq.size() == 0}) begin
                errors++; $display("FAIL rnd_stat cyc%0d got %h exp cyc=%0d inst=%0d drop=%0d ovf=%b h=%b", i, stat, m_cyc, m_inst, m_drop, m_ovf, m_halted);
            end
            if (i < 650) begin
                en = $urandom_range(0, 9) != 0;
                reg_we = $urandom_range(0, 1) == 1;
                mem_re = $urandom_range(0, 3) == 0;
                mem_we = $urandom_range(0, 3) == 0;
                halt = i > 550 && $urandom_range(0, 40) == 0;
                reg_waddr = 4'($urandom); reg_wdata = 16'($urandom);
                mem_addr = 16'($urandom); mem_wdata = 16'($urandom); mem_rdata = 16'($urandom);
                trc_ready = $urandom_range(0, 2) != 0;
            end else begin
                idle(); trc_ready = 1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_flag();
        test_overflow();
        test_backpressure();
        test_halt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
